alu_op_collector: RTL and testbench
===================================

# alu_op_collector

Upstream operand-collection stage for the ALU. Accepts a command request and its two operands, which may arrive on separate cycles. Once every operand the command needs has been captured, it presents one aligned issue cycle to the ALU input port (ce, mode, cmd, cin, inp_valid, opa, opb). A programmable timeout forces a partial issue when an operand never arrives, so the ALU raises its own err.

## Interface
Parameters:
- DATA_WIDTH, 8, operand width
- CMD_WIDTH, 4, command width
- TIMEOUT_CYC, 16, maximum COLLECT cycles before a forced partial issue (≥2)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  command request valid
- req_ready  out  1  collector can accept a request
- req_cmd  in  CMD_WIDTH  ALU command
- req_mode  in  1  ALU mode
- req_cin  in  1  carry-in
- req_need  in  2  operands required: bit0 = opa, bit1 = opb
- opa_valid  in  1  opa present this cycle
- opa  in  DATA_WIDTH  operand A
- opb_valid  in  1  opb present this cycle
- opb  in  DATA_WIDTH  operand B
- alu_ce  out  1  issue strobe to ALU
- alu_mode, alu_cin  out  1 each  issued mode, carry-in
- alu_cmd  out  CMD_WIDTH  issued command
- alu_inp_valid  out  2  operands actually captured: bit0 = A, bit1 = B
- alu_opa, alu_opb  out  DATA_WIDTH each  issued operands
- timeout  out  1  pulse: current issue is partial because of timeout
- busy  out  1  request in flight

## Operation
- FSM states: IDLE, COLLECT, ISSUE.
- IDLE:
  - req_ready = 1.
  - Request is accepted when req_valid = 1. Capture cmd, mode, cin and need; clear got[1:0] and cnt.
  - Operands whose valid is high in the accept cycle are captured in that same cycle.
- COLLECT:
  - An operand is captured when its valid is high, its need bit is set and its got bit is clear.
  - Repeat deliveries after capture are ignored. Operands that are not needed are ignored.
- Complete means (got_next & need) == need. need = 2'b00 is complete immediately.
- Transitions:
  - IDLE→ISSUE on accept if complete that cycle.
  - IDLE→COLLECT on accept otherwise.
  - COLLECT→ISSUE when complete.
  - COLLECT→ISSUE with timeout flag when cnt == TIMEOUT_CYC−1 and not complete.
  - Otherwise stay in COLLECT with cnt+1.
  - ISSUE→IDLE unconditionally.
- ISSUE cycle outputs:
  - alu_ce = 1.
  - alu_inp_valid = got.
  - alu_opa/alu_opb = captured value, or 0 if not captured.
  - alu_cmd/mode/cin = captured values.
  - timeout = 1 only for a forced partial issue.
- Outside ISSUE:
  - alu_ce = 0 and timeout = 0.
  - All other alu_* outputs hold the last issued values.
- busy = (state != IDLE). req_ready = (state == IDLE).
- Reset values: every output 0 except req_ready = 1. State is IDLE, got = 0, cnt = 0.
- Reset mid-operation discards the captured request and operands. There is no issue, and outputs return to reset values asynchronously.

## Timing
- All alu_* outputs and timeout are registered, with no combinational path from inputs to them.
- Request and all needed operands present in the accept cycle T → alu_ce high in T+1, req_ready high again in T+2.
- Last needed operand captured in cycle N (N > T) → alu_ce high in N+1.
- Request accepted at T with an operand missing → COLLECT occupies T+1 … T+TIMEOUT_CYC at most, and the forced issue occurs in T+TIMEOUT_CYC+1.
- alu_ce is exactly one cycle wide. Back-to-back requests are spaced at least 2 cycles apart.
- Operand arriving in the final COLLECT cycle → normal complete issue, timeout = 0.

## Configuration
- ALU_COLLECT_TIMEOUT_EN defined:
  - The timeout counter and forced partial issue are present as described.
- ALU_COLLECT_TIMEOUT_EN undefined:
  - No counter. COLLECT waits indefinitely for all needed operands.
  - timeout is tied to 0 and TIMEOUT_CYC is unused.

## Test plan
- Reset value check:
  - Assert rst asynchronously mid-cycle → outputs 0 immediately, req_ready = 1.
  - Release rst → first request at the next edge is accepted.
- Same-cycle accept:
  - Request cmd=4'h0, need=2'b11, opa=8'h12, opb=8'h34, all valid at cycle 5.
  - Cycle 6: alu_ce=1, alu_inp_valid=2'b11, alu_opa=8'h12, alu_opb=8'h34.
  - Cycle 7: req_ready=1.
- Split arrival with ignored repeat:
  - Request at 0, need=2'b11, opa=8'hAA at 0, opa=8'h55 at 2, opb=8'h0F at 4.
  - Cycle 5: alu_ce=1, alu_opa=8'hAA, alu_opb=8'h0F, timeout=0.
- Single-operand command:
  - need=2'b01, opa=8'h80 with the request at 0, opb_valid=1 opb=8'hFF also at 0.
  - Cycle 1: alu_inp_valid=2'b01, alu_opb=8'h00.
- Timeout (macro defined, TIMEOUT_CYC=16):
  - Request at 0, need=2'b11, only opa=8'h07 at 0.
  - Cycle 17: alu_ce=1, alu_inp_valid=2'b01, timeout=1.
  - Repeat with opb arriving at cycle 16 → cycle 17 issue with inp_valid=2'b11, timeout=0.
- Reset mid-COLLECT:
  - Request at 0, need=2'b11, opa only.
  - rst pulse at cycle 3 → no alu_ce ever for that request, busy=0, state IDLE.
  - Macro undefined: the same stimulus without reset → no issue after 100 cycles, busy=1.

Source files
------------

// File: rtl/alu_op_collector.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : alu_op_collector                                                 |
// | Brief    : collects a command and its operands, then issues one aligned    |
// |            cycle to the ALU. Optional timeout: ALU_COLLECT_TIMEOUT_EN.      |
// | Revision : 1.0 - initial release                                            |
// +-----------------------------------------------------------------------------+
module alu_op_collector #(
  parameter int DATA_WIDTH  = 8,
  parameter int CMD_WIDTH   = 4,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [CMD_WIDTH-1:0]  req_cmd,
  input  logic                  req_mode,
  input  logic                  req_cin,
  input  logic [1:0]            req_need,
  input  logic                  opa_valid,
  input  logic [DATA_WIDTH-1:0] opa,
  input  logic                  opb_valid,
  input  logic [DATA_WIDTH-1:0] opb,
  output logic                  alu_ce,
  output logic                  alu_mode,
  output logic                  alu_cin,
  output logic [CMD_WIDTH-1:0]  alu_cmd,
  output logic [1:0]            alu_inp_valid,
  output logic [DATA_WIDTH-1:0] alu_opa,
  output logic [DATA_WIDTH-1:0] alu_opb,
  output logic                  timeout,
  output logic                  busy
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_ISSUE   = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [1:0]            need_q, need_d;
  logic [1:0]            got_q, got_d;
  logic [CMD_WIDTH-1:0]  cmd_q, cmd_d;
  logic                  mode_q, mode_d;
  logic                  cin_q, cin_d;
  logic [DATA_WIDTH-1:0] opa_q, opa_d;
  logic [DATA_WIDTH-1:0] opb_q, opb_d;

  logic                  alu_ce_q, alu_ce_d;
  logic                  alu_mode_q, alu_mode_d;
  logic                  alu_cin_q, alu_cin_d;
  logic [CMD_WIDTH-1:0]  alu_cmd_q, alu_cmd_d;
  logic [1:0]            alu_inp_valid_q, alu_inp_valid_d;
  logic [DATA_WIDTH-1:0] alu_opa_q, alu_opa_d;
  logic [DATA_WIDTH-1:0] alu_opb_q, alu_opb_d;
  logic                  timeout_q, timeout_d;

  logic [1:0]            cap;
  logic                  complete;
  logic                  expire;

`ifdef ALU_COLLECT_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`else
  logic unused_cfg;
  assign unused_cfg = (TIMEOUT_CYC < 2);
`endif

  always_comb begin
    state_d  = state_q;
    need_d   = need_q;
    got_d    = got_q;
    cmd_d    = cmd_q;
    mode_d   = mode_q;
    cin_d    = cin_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    cap      = 2'b00;
    complete = 1'b0;
    expire   = 1'b0;
`ifdef ALU_COLLECT_TIMEOUT_EN
    cnt_d    = cnt_q;
`endif
    alu_ce_d        = 1'b0;
    timeout_d       = 1'b0;
    alu_mode_d      = alu_mode_q;
    alu_cin_d       = alu_cin_q;
    alu_cmd_d       = alu_cmd_q;
    alu_inp_valid_d = alu_inp_valid_q;
    alu_opa_d       = alu_opa_q;
    alu_opb_d       = alu_opb_q;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          need_d   = req_need;
          cmd_d    = req_cmd;
          mode_d   = req_mode;
          cin_d    = req_cin;
          cap      = {opb_valid, opa_valid} & req_need;
          got_d    = cap;
          // Uncaptured operands are zeroed so the issue presents 0 for them.
          opa_d    = cap[0] ? opa : '0;
          opb_d    = cap[1] ? opb : '0;
          complete = ((got_d & req_need) == req_need);
`ifdef ALU_COLLECT_TIMEOUT_EN
          cnt_d    = '0;
`endif
          state_d  = complete ? ST_ISSUE : ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        cap      = {opb_valid, opa_valid} & need_q & ~got_q;
        got_d    = got_q | cap;
        opa_d    = cap[0] ? opa : opa_q;
        opb_d    = cap[1] ? opb : opb_q;
        complete = ((got_d & need_q) == need_q);
`ifdef ALU_COLLECT_TIMEOUT_EN
        expire   = !complete && (cnt_q == CNT_LAST);
        if (!complete && !expire) begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
        if (complete || expire) begin
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    // Issue registers load on entry to ISSUE so they line up with that cycle.
    if (state_d == ST_ISSUE) begin
      alu_ce_d        = 1'b1;
      timeout_d       = expire;
      alu_mode_d      = mode_d;
      alu_cin_d       = cin_d;
      alu_cmd_d       = cmd_d;
      alu_inp_valid_d = got_d;
      alu_opa_d       = opa_d;
      alu_opb_d       = opb_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      need_q          <= '0;
      got_q           <= '0;
      cmd_q           <= '0;
      mode_q          <= 1'b0;
      cin_q           <= 1'b0;
      opa_q           <= '0;
      opb_q           <= '0;
      alu_ce_q        <= 1'b0;
      alu_mode_q      <= 1'b0;
      alu_cin_q       <= 1'b0;
      alu_cmd_q       <= '0;
      alu_inp_valid_q <= '0;
      alu_opa_q       <= '0;
      alu_opb_q       <= '0;
      timeout_q       <= 1'b0;
`ifdef ALU_COLLECT_TIMEOUT_EN
      cnt_q           <= '0;
`endif
    end else begin
      state_q         <= state_d;
      need_q          <= need_d;
      got_q           <= got_d;
      cmd_q           <= cmd_d;
      mode_q          <= mode_d;
      cin_q           <= cin_d;
      opa_q           <= opa_d;
      opb_q           <= opb_d;
      alu_ce_q        <= alu_ce_d;
      alu_mode_q      <= alu_mode_d;
      alu_cin_q       <= alu_cin_d;
      alu_cmd_q       <= alu_cmd_d;
      alu_inp_valid_q <= alu_inp_valid_d;
      alu_opa_q       <= alu_opa_d;
      alu_opb_q       <= alu_opb_d;
      timeout_q       <= timeout_d;
`ifdef ALU_COLLECT_TIMEOUT_EN
      cnt_q           <= cnt_d;
`endif
    end
  end

  assign req_ready     = (state_q == ST_IDLE);
  assign busy          = (state_q != ST_IDLE);
  assign alu_ce        = alu_ce_q;
  assign alu_mode      = alu_mode_q;
  assign alu_cin       = alu_cin_q;
  assign alu_cmd       = alu_cmd_q;
  assign alu_inp_valid = alu_inp_valid_q;
  assign alu_opa       = alu_opa_q;
  assign alu_opb       = alu_opb_q;
  assign timeout       = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_op_collector.sv
`default_nettype none
// Randomized bench for alu_op_collector: each transaction's expected issue cycle
// and payload come from the operand arrival times, not from the design's state.
module tb_alu_op_collector;

  localparam int DW    = 8;
  localparam int CW    = 4;
  localparam int TO    = 16;
  localparam int NEVER = 1000;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_ready, req_mode, req_cin;
  logic [CW-1:0] req_cmd;
  logic [1:0]    req_need;
  logic          opa_valid, opb_valid;
  logic [DW-1:0] opa, opb;
  logic          alu_ce, alu_mode, alu_cin, timeout, busy;
  logic [CW-1:0] alu_cmd;
  logic [1:0]    alu_inp_valid;
  logic [DW-1:0] alu_opa, alu_opb;

  int n_checks = 0;
  int n_pass   = 0;

  logic [DW-1:0] last_opa, last_opb;
  logic [1:0]    last_iv;
  logic [CW-1:0] last_cmd;
  logic          last_mode, last_cin;

  alu_op_collector #(.DATA_WIDTH(DW), .CMD_WIDTH(CW), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd),
    .req_mode(req_mode), .req_cin(req_cin), .req_need(req_need),
    .opa_valid(opa_valid), .opa(opa), .opb_valid(opb_valid), .opb(opb),
    .alu_ce(alu_ce), .alu_mode(alu_mode), .alu_cin(alu_cin), .alu_cmd(alu_cmd),
    .alu_inp_valid(alu_inp_valid), .alu_opa(alu_opa), .alu_opb(alu_opb),
    .timeout(timeout), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic drive_idle();
    req_valid = 1'b0; req_cmd = '0; req_mode = 1'b0; req_cin = 1'b0; req_need = 2'b00;
    opa_valid = 1'b0; opa = '0; opb_valid = 1'b0; opb = '0;
  endtask

  task automatic clear_last();
    last_opa = '0; last_opb = '0; last_iv = '0; last_cmd = '0; last_mode = 1'b0; last_cin = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ce"},    32'(alu_ce), 32'(0));
    check({tag, "_iv"},    32'(alu_inp_valid), 32'(0));
    check({tag, "_opa"},   32'(alu_opa), 32'(0));
    check({tag, "_opb"},   32'(alu_opb), 32'(0));
    check({tag, "_cmd"},   32'({alu_mode, alu_cin, alu_cmd}), 32'(0));
    check({tag, "_to"},    32'(timeout), 32'(0));
    check({tag, "_busy"},  32'(busy), 32'(0));
    check({tag, "_ready"}, 32'(req_ready), 32'(1));
  endtask

  // One request; a_at/b_at are the cycles (relative to accept) of first delivery.
  task automatic run_txn(input logic [1:0] need, input logic [CW-1:0] cmd, input logic mode,
                         input logic cin, input int a_at, input logic [DW-1:0] va,
                         input int b_at, input logic [DW-1:0] vb);
    int tend, c, issue;
    logic [1:0] got;
    logic to;
`ifdef ALU_COLLECT_TIMEOUT_EN
    tend = TO;
`else
    tend = 1000000;
`endif
    c = 0;
    if (need[0] && a_at > c) c = a_at;
    if (need[1] && b_at > c) c = b_at;
    if (c <= tend) begin
      issue = c + 1; got = need; to = 1'b0;
    end else begin
      issue = tend + 1; to = 1'b1;
      got = {need[1] && (b_at <= tend), need[0] && (a_at <= tend)};
    end
    for (int k = 0; k <= issue; k++) begin
      @(posedge clk); #1;
      check("ce",      32'(alu_ce),    32'(k == issue));
      check("busy",    32'(busy),      32'(k != 0));
      check("ready",   32'(req_ready), 32'(k == 0));
      check("timeout", 32'(timeout),   32'((k == issue) && to));
      if (k == 0) begin
        check("hold_opa", 32'(alu_opa), 32'(last_opa));
        check("hold_opb", 32'(alu_opb), 32'(last_opb));
        check("hold_iv",  32'(alu_inp_valid), 32'(last_iv));
        check("hold_cmd", 32'({alu_mode, alu_cin, alu_cmd}), 32'({last_mode, last_cin, last_cmd}));
      end
      if (k == issue) begin
        last_iv   = got;
        last_opa  = got[0] ? va : '0;
        last_opb  = got[1] ? vb : '0;
        last_cmd  = cmd; last_mode = mode; last_cin = cin;
        check("iv",  32'(alu_inp_valid), 32'(last_iv));
        check("opa", 32'(alu_opa), 32'(last_opa));
        check("opb", 32'(alu_opb), 32'(last_opb));
        check("cmd", 32'({alu_mode, alu_cin, alu_cmd}), 32'({mode, cin, cmd}));
      end
      // Outside the accept cycle the request lines carry junk that must be ignored.
      req_valid = (k == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      req_cmd   = (k == 0) ? cmd  : CW'($urandom);
      req_mode  = (k == 0) ? mode : 1'($urandom_range(0, 1));
      req_cin   = (k == 0) ? cin  : 1'($urandom_range(0, 1));
      req_need  = (k == 0) ? need : 2'($urandom_range(0, 3));
      if (need[0]) begin
        opa_valid = (k == a_at) || ((k > a_at) && ($urandom_range(0, 1) == 1));
        opa       = (k == a_at) ? va : DW'($urandom);
      end else begin
        opa_valid = 1'($urandom_range(0, 1));
        opa       = DW'($urandom);
      end
      if (need[1]) begin
        opb_valid = (k == b_at) || ((k > b_at) && ($urandom_range(0, 1) == 1));
        opb       = (k == b_at) ? vb : DW'($urandom);
      end else begin
        opb_valid = 1'($urandom_range(0, 1));
        opb       = DW'($urandom);
      end
    end
  endtask

  function automatic int pick_at();
    int r;
    r = int'($urandom_range(0, 9));
    if (r < 6) return int'($urandom_range(0, 3));
`ifdef ALU_COLLECT_TIMEOUT_EN
    if (r == 9) return NEVER;
`endif
    return int'($urandom_range(0, 20));
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    rst = 1'b1;
    drive_idle();
    clear_last();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("por");
    #2 rst = 1'b0;

    run_txn(2'b11, 4'h0, 1'b0, 1'b0, 0, 8'h12, 0, 8'h34);
    run_txn(2'b11, 4'h1, 1'b1, 1'b0, 0, 8'hAA, 4, 8'h0F);
    run_txn(2'b01, 4'h2, 1'b0, 1'b1, 0, 8'h80, 0, 8'hFF);
    run_txn(2'b00, 4'h9, 1'b1, 1'b1, 0, 8'h00, 0, 8'h00);
`ifdef ALU_COLLECT_TIMEOUT_EN
    run_txn(2'b11, 4'h3, 1'b0, 1'b1, 0, 8'h07, NEVER, 8'h00);
    run_txn(2'b11, 4'h4, 1'b1, 1'b0, 0, 8'h07, 16, 8'h99);
    run_txn(2'b10, 4'h5, 1'b0, 1'b0, 0, 8'h00, 17, 8'h42);
`endif
    for (int i = 0; i < 40; i++) begin
      run_txn(2'($urandom_range(0, 3)), CW'($urandom), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), pick_at(), DW'($urandom), pick_at(), DW'($urandom));
    end

    // Asynchronous reset in the middle of a collection.
    run_txn(2'b11, 4'hC, 1'b1, 1'b1, 0, 8'hC3, 0, 8'h5A);
    @(posedge clk); #1;
    req_valid = 1'b1; req_need = 2'b11; req_cmd = 4'h5; req_mode = 1'b1; req_cin = 1'b1;
    opa_valid = 1'b1; opa = 8'h3C; opb_valid = 1'b0; opb = 8'h00;
    @(posedge clk); #1;
    drive_idle();
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    #1 check_reset_outputs("arst");
    #2 rst = 1'b0;
    clear_last();
    seen = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (alu_ce) seen++;
    end
    check("no_issue_after_rst", 32'(seen), 32'(0));
    check("busy_after_rst", 32'(busy), 32'(0));
    run_txn(2'b11, 4'h6, 1'b0, 1'b1, 1, 8'h21, 0, 8'h43);

`ifndef ALU_COLLECT_TIMEOUT_EN
    // Without the timeout the collector waits forever for the missing operand.
    @(posedge clk); #1;
    req_valid = 1'b1; req_need = 2'b11; req_cmd = 4'h7;
    opa_valid = 1'b1; opa = 8'h07; opb_valid = 1'b0;
    @(posedge clk); #1;
    drive_idle();
    seen = 0;
    repeat (100) begin
      @(posedge clk); #1;
      if (alu_ce) seen++;
    end
    check("wait_no_issue", 32'(seen), 32'(0));
    check("wait_busy", 32'(busy), 32'(1));
    check("wait_to", 32'(timeout), 32'(0));
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    clear_last();
    run_txn(2'b10, 4'h8, 1'b1, 1'b0, 0, 8'h00, 2, 8'hE1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
